// File: rtl/mmu_bus_pkg.sv
// Shared MMU bus types and constants.
// Used by the arbiter and anything else that drives the mmu port.
package mmu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  localparam logic MMU_WRITE_MODE = 1'b1;
  localparam logic MMU_READ_MODE  = 1'b0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
  } mmu_txn_t;

  function automatic int next_idx(int cur, int n);
    return (cur + 1) % n;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first eligible bit
// scanning upward from ptr, wrapping modulo N.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int k;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && eligible[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/mmu_arbiter.sv
// Round-robin arbiter with optional lock sharing the single
// MMU port; one 3-cycle transaction at a time.
module mmu_arbiter
  import mmu_bus_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ-1:0]    req_lock,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic [31:0]           mmu_address,
  output logic                  mmu_mode,
  output logic [31:0]           mmu_data_in,
  input  logic [31:0]           mmu_data_out
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  arb_state_t state;
  arb_state_t state_nx;

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] lock_owner;
  logic          lock_held;
  logic [CW-1:0] to_cnt;
  mmu_txn_t      txn;

  logic [NUM_REQ-1:0] own_mask;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               accept;
  logic               lock_idle;

  logic [31:0] addr_arr  [NUM_REQ];
  logic [31:0] wdata_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[32*i +: 32];
      wdata_arr[i] = req_wdata[32*i +: 32];
    end
  end

  // While a lock is held only its owner may compete.
  always_comb begin
    own_mask             = '0;
    own_mask[lock_owner] = 1'b1;
    eligible = lock_held ? (req_valid & own_mask) : req_valid;
  end

  rr_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .grant    (pick_grant),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  assign accept    = (state == IDLE) && pick_any && !reset;
  assign lock_idle = (state == IDLE) && lock_held &&
                     !req_valid[lock_owner];

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_rdata   = '0;
    mmu_mode    = MMU_READ_MODE;
    mmu_address = txn.addr;
    mmu_data_in = txn.wdata;
    if (accept) req_ready = pick_grant;
    if (state == ACCESS && txn.write) mmu_mode = MMU_WRITE_MODE;
    if (state == RESP && !reset) begin
      rsp_valid[owner] = 1'b1;
      if (!txn.write) rsp_rdata = mmu_data_out;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      lock_owner <= '0;
      lock_held  <= 1'b0;
      to_cnt     <= '0;
      txn        <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        txn.addr   <= addr_arr[pick_idx];
        txn.wdata  <= wdata_arr[pick_idx];
        txn.write  <= req_write[pick_idx];
        owner      <= pick_idx;
        lock_owner <= pick_idx;
        lock_held  <= req_lock[pick_idx];
        to_cnt     <= '0;
      end else if (lock_idle) begin
        if (to_cnt == CW'(LOCK_TIMEOUT - 1)) begin
          lock_held <= 1'b0;
          to_cnt    <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
      if (state == RESP)
        rr_ptr <= IW'(next_idx(int'(owner), NUM_REQ));
    end
  end

endmodule

// File: tb/tb_mmu_arbiter.sv
// Directed bench for mmu_arbiter with a behavioural
// registered-read MMU model.
module tb_mmu_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [1:0]  req_lock;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic [31:0] mmu_address;
  logic        mmu_mode;
  logic [31:0] mmu_data_in;
  logic [31:0] mmu_data_out;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mmu_arbiter #(
    .NUM_REQ      (2),
    .LOCK_TIMEOUT (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_lock     (req_lock),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .mmu_address  (mmu_address),
    .mmu_mode     (mmu_mode),
    .mmu_data_in  (mmu_data_in),
    .mmu_data_out (mmu_data_out)
  );

  // MMU model: written words override a fixed preload image.
  logic [31:0] mem     [256];
  logic        written [256];

  function automatic logic [31:0] preload(logic [7:0] a);
    if (a == 8'h60) return 32'hDEADBEEF;
    if (a == 8'h90) return 32'h0000_0005;
    return 32'h0;
  endfunction

  always @(posedge clock) begin
    mmu_data_out <= written[mmu_address[7:0]] ?
                    mem[mmu_address[7:0]] : preload(mmu_address[7:0]);
    if (mmu_mode) begin
      mem[mmu_address[7:0]]     <= mmu_data_in;
      written[mmu_address[7:0]] <= 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) written[i] = 1'b0;
  end

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic outs_zero(string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'h0);
    chk({tag, "_rspv"},  32'(rsp_valid), 32'h0);
    chk({tag, "_rdata"}, rsp_rdata,      32'h0);
    chk({tag, "_addr"},  mmu_address,    32'h0);
    chk({tag, "_mode"},  32'(mmu_mode),  32'h0);
    chk({tag, "_din"},   mmu_data_in,    32'h0);
  endtask

  logic [1:0]  exp_g [4];
  logic [31:0] exp_d [4];

  initial begin
    reset     = 1'b1;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_lock  = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    tick;
    tick;
    settle;
    outs_zero("reset");

    // single read of preloaded word
    tick;
    reset     = 1'b0;
    req_valid = 2'b01;
    req_addr[31:0] = 32'h60;
    settle;
    chk("t1_ready", 32'(req_ready), 32'h1);
    tick;
    req_valid = 2'b00;
    settle;
    chk("t1_addr", mmu_address, 32'h60);
    chk("t1_mode", 32'(mmu_mode), 32'h0);
    chk("t1_rspv_early", 32'(rsp_valid), 32'h0);
    tick;
    settle;
    chk("t1_rspv", 32'(rsp_valid), 32'h1);
    chk("t1_rdata", rsp_rdata, 32'hDEADBEEF);
    tick;

    // req1 write then read back
    req_valid = 2'b10;
    req_write = 2'b10;
    req_addr[63:32]  = 32'h80;
    req_wdata[63:32] = 32'h1234;
    settle;
    chk("t2_wready", 32'(req_ready), 32'h2);
    chk("t2_idle_mode", 32'(mmu_mode), 32'h0);
    tick;
    req_valid = 2'b00;
    settle;
    chk("t2_wmode", 32'(mmu_mode), 32'h1);
    chk("t2_waddr", mmu_address, 32'h80);
    chk("t2_wdin", mmu_data_in, 32'h1234);
    tick;
    settle;
    chk("t2_resp_mode", 32'(mmu_mode), 32'h0);
    chk("t2_wrspv", 32'(rsp_valid), 32'h2);
    chk("t2_wrdata", rsp_rdata, 32'h0);
    tick;
    req_valid = 2'b10;
    req_write = 2'b00;
    settle;
    chk("t2_rready", 32'(req_ready), 32'h2);
    tick;
    req_valid = 2'b00;
    settle;
    chk("t2_rmode", 32'(mmu_mode), 32'h0);
    tick;
    settle;
    chk("t2_rrspv", 32'(rsp_valid), 32'h2);
    chk("t2_rdata", rsp_rdata, 32'h1234);
    tick;

    // contention from reset
    reset     = 1'b1;
    req_valid = 2'b11;
    req_addr  = {32'h80, 32'h60};
    settle;
    chk("t3_ready_in_reset", 32'(req_ready), 32'h0);
    tick;
    reset = 1'b0;
    exp_g[0] = 2'b01; exp_d[0] = 32'hDEADBEEF;
    exp_g[1] = 2'b10; exp_d[1] = 32'h1234;
    exp_g[2] = 2'b01; exp_d[2] = 32'hDEADBEEF;
    exp_g[3] = 2'b10; exp_d[3] = 32'h1234;
    for (int t = 0; t < 4; t++) begin
      settle;
      chk($sformatf("t3_ready%0d", t), 32'(req_ready), 32'(exp_g[t]));
      tick;
      settle;
      chk($sformatf("t3_busy%0d", t), 32'(req_ready), 32'h0);
      tick;
      settle;
      chk($sformatf("t3_rspv%0d", t), 32'(rsp_valid), 32'(exp_g[t]));
      chk($sformatf("t3_rdata%0d", t), rsp_rdata, exp_d[t]);
      tick;
    end

    // locked read-modify-write on 0x90 while req1 waits
    req_valid = 2'b11;
    req_lock  = 2'b01;
    req_write = 2'b00;
    req_addr  = {32'h60, 32'h90};
    settle;
    chk("t4_ready_a", 32'(req_ready), 32'h1);
    tick;
    req_lock  = 2'b00;
    req_write = 2'b01;
    req_wdata[31:0] = 32'h6;
    settle;
    chk("t4_busy", 32'(req_ready), 32'h0);
    tick;
    settle;
    chk("t4_rspv_a", 32'(rsp_valid), 32'h1);
    chk("t4_rdata_a", rsp_rdata, 32'h5);
    tick;
    settle;
    chk("t4_ready_b", 32'(req_ready), 32'h1);
    tick;
    settle;
    chk("t4_mode_b", 32'(mmu_mode), 32'h1);
    chk("t4_addr_b", mmu_address, 32'h90);
    chk("t4_din_b", mmu_data_in, 32'h6);
    tick;
    settle;
    chk("t4_rspv_b", 32'(rsp_valid), 32'h1);
    chk("t4_rdata_b", rsp_rdata, 32'h0);
    tick;
    settle;
    chk("t4_ready_c", 32'(req_ready), 32'h2);
    tick;
    req_valid = 2'b00;
    req_write = 2'b00;
    tick;
    settle;
    chk("t4_rspv_c", 32'(rsp_valid), 32'h2);
    chk("t4_rdata_c", rsp_rdata, 32'hDEADBEEF);
    tick;

    // lock timeout: owner goes quiet, req1 waits out 4 IDLE cycles
    req_valid = 2'b11;
    req_lock  = 2'b01;
    settle;
    chk("t5_ready_a", 32'(req_ready), 32'h1);
    tick;
    req_valid = 2'b10;
    req_lock  = 2'b00;
    tick;
    settle;
    chk("t5_rspv_a", 32'(rsp_valid), 32'h1);
    chk("t5_rdata_a", rsp_rdata, 32'h6);
    tick;
    for (int c = 0; c < 4; c++) begin
      settle;
      chk($sformatf("t5_locked%0d", c), 32'(req_ready), 32'h0);
      tick;
    end
    settle;
    chk("t5_ready_b", 32'(req_ready), 32'h2);
    tick;
    req_valid = 2'b00;
    tick;
    settle;
    chk("t5_rspv_b", 32'(rsp_valid), 32'h2);
    tick;

    // reset in the ACCESS cycle of a write
    req_valid = 2'b01;
    req_write = 2'b01;
    req_addr[31:0]  = 32'hA0;
    req_wdata[31:0] = 32'hBAD;
    settle;
    chk("t6_ready", 32'(req_ready), 32'h1);
    tick;
    req_valid = 2'b00;
    req_write = 2'b00;
    reset     = 1'b1;
    settle;
    chk("t6_mode_access", 32'(mmu_mode), 32'h1);
    tick;
    reset = 1'b0;
    settle;
    outs_zero("t6_after");
    tick;
    settle;
    chk("t6_no_rsp", 32'(rsp_valid), 32'h0);
    req_valid = 2'b10;
    req_addr[63:32] = 32'h60;
    settle;
    chk("t6_ready_next", 32'(req_ready), 32'h2);
    tick;
    req_valid = 2'b00;
    tick;
    settle;
    chk("t6_rspv_next", 32'(rsp_valid), 32'h2);
    chk("t6_rdata_next", rsp_rdata, 32'hDEADBEEF);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
